// File: rtl/upstream_link_pkg.sv
// Shared types and default configuration for the upstream link transmitter.
package upstream_link_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  localparam int DEF_CORE_W        = 64;
  localparam int DEF_CH_NUM        = 2;
  localparam int DEF_CH_W          = 8;
  localparam int DEF_CREDIT_MAX    = 8;
  localparam int DEF_TOKEN_CREDITS = 4;
  localparam int DEF_FIFO_DEPTH    = 2;

  function automatic int calc_beats(input int core_w, input int ch_num, input int ch_w);
    return core_w / (ch_num * ch_w);
  endfunction

endpackage

// File: rtl/upstream_tx_fifo.sv
// Small circular-buffer FIFO holding core words ahead of the serializer.
module upstream_tx_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push_s;
  logic             do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    else return p + PW'(1);
  endfunction

  assign do_push_s = push_i && (count_q != CW'(DEPTH));
  assign do_pop_s  = pop_i && (count_q != CW'(0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop_s)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(do_push_s) - CW'(do_pop_s);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == CW'(0));
  assign count_o = count_q;

endmodule

// File: rtl/upstream_link_tx.sv
// Credit-based core-to-link serializer: FIFO, beat FSM and token credit return.
// Optional io_parity_out is enabled by defining UPSTREAM_TX_PARITY_EN.
module upstream_link_tx
  import upstream_link_pkg::*;
#(
  parameter int CORE_W        = DEF_CORE_W,
  parameter int CH_NUM        = DEF_CH_NUM,
  parameter int CH_W          = DEF_CH_W,
  parameter int CREDIT_MAX    = DEF_CREDIT_MAX,
  parameter int TOKEN_CREDITS = DEF_TOKEN_CREDITS,
  parameter int FIFO_DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     core_valid_in,
  input  logic [CORE_W-1:0]        core_data_in,
  output logic                     core_ready_out,
  input  logic                     io_token,
  output logic                     io_valid_out,
  output logic [CH_NUM*CH_W-1:0]   io_data_out,
  output logic                     credit_err
`ifdef UPSTREAM_TX_PARITY_EN
  ,
  output logic [CH_NUM-1:0]        io_parity_out
`endif
);
  localparam int BEAT_W = CH_NUM * CH_W;
  localparam int BEATS  = calc_beats(CORE_W, CH_NUM, CH_W);
  localparam int IW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OW     = $clog2(CREDIT_MAX) + 1;
  localparam int CW     = $clog2(FIFO_DEPTH + 1);

  if (((CORE_W % BEAT_W) != 0) || (BEATS < 1)) begin : g_cfg_check
    $error("upstream_link_tx: CORE_W must be a non-zero multiple of CH_NUM*CH_W");
  end

  tx_state_e         state_q;
  logic [IW-1:0]     idx_q;
  logic [CORE_W-1:0] word_q;
  logic              valid_q;
  logic [BEAT_W-1:0] data_q;
  logic [OW-1:0]     outstanding_q;
  logic [OW-1:0]     outstanding_d;
  logic [OW-1:0]     out_inc_s;
  logic              tok_q;
  logic              tok_prev_q;
  logic              credit_err_q;
  logic              ready_q;
  logic              push_s;
  logic              pop_s;
  logic              can_start_s;
  logic              last_beat_s;
  logic              token_s;
  logic              underflow_s;
  logic [CW-1:0]     count_s;
  logic [CW-1:0]     count_d;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CORE_W-1:0] head_s;
  logic [BEAT_W-1:0] beat_d;

  upstream_tx_fifo #(
    .WIDTH (CORE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .data_i  (core_data_in),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (count_s)
  );

  assign push_s      = core_valid_in & ready_q & ~fifo_full_s;
  assign can_start_s = ~fifo_empty_s & (outstanding_q < OW'(CREDIT_MAX));
  assign last_beat_s = (idx_q == IW'(BEATS - 1));
  assign token_s     = tok_q & ~tok_prev_q;
  assign count_d     = count_s + CW'(push_s) - CW'(pop_s);

  // A pop on the last beat of a frame chains the next frame without a bubble.
  always_comb begin
    pop_s  = 1'b0;
    beat_d = '0;
    case (state_q)
      ST_IDLE: pop_s = can_start_s;
      ST_SEND: pop_s = last_beat_s & can_start_s;
      default: pop_s = 1'b0;
    endcase
    if (pop_s) beat_d = head_s[BEAT_W-1:0];
    else if ((state_q == ST_SEND) && !last_beat_s) beat_d = word_q[(int'(idx_q) + 1) * BEAT_W +: BEAT_W];
    else beat_d = '0;
  end

  always_comb begin
    out_inc_s     = outstanding_q + OW'(pop_s);
    outstanding_d = out_inc_s;
    underflow_s   = 1'b0;
    if (token_s && (out_inc_s < OW'(TOKEN_CREDITS))) begin
      outstanding_d = '0;
      underflow_s   = 1'b1;
    end else if (token_s) begin
      outstanding_d = out_inc_s - OW'(TOKEN_CREDITS);
    end else begin
      outstanding_d = out_inc_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_q         <= 1'b0;
      tok_prev_q    <= 1'b0;
      outstanding_q <= '0;
      credit_err_q  <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      tok_q         <= io_token;
      tok_prev_q    <= tok_q;
      outstanding_q <= outstanding_d;
      credit_err_q  <= credit_err_q | underflow_s;
      ready_q       <= (count_d < CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      data_q <= beat_d;
      case (state_q)
        ST_IDLE: begin
          if (pop_s) begin
            state_q <= ST_SEND;
            idx_q   <= '0;
            word_q  <= head_s;
            valid_q <= 1'b1;
          end else begin
            valid_q <= 1'b0;
          end
        end
        ST_SEND: begin
          if (pop_s) begin
            idx_q   <= '0;
            word_q  <= head_s;
            valid_q <= 1'b1;
          end else if (last_beat_s) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
          end else begin
            idx_q   <= idx_q + IW'(1);
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign core_ready_out = ready_q;
  assign io_valid_out   = valid_q;
  assign io_data_out    = data_q;
  assign credit_err     = credit_err_q;

`ifdef UPSTREAM_TX_PARITY_EN
  logic [CH_NUM-1:0] parity_q;

  // Bit c is 1 when channel c of the beat carries an odd number of ones.
  function automatic logic [CH_NUM-1:0] beat_parity(input logic [BEAT_W-1:0] beat);
    logic [CH_NUM-1:0] p;
    p = '0;
    for (int c = 0; c < CH_NUM; c++) p[c] = ^beat[c*CH_W +: CH_W];
    return p;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= '0;
    else parity_q <= beat_parity(beat_d);
  end

  assign io_parity_out = parity_q;
`endif

endmodule
